// File: rtl/output_port_bank_if.sv
// output_port_bank_if: write/commit/readback bus between the control unit and the indicator bank
// i_rw/i_op/i_data/i_port_id: slot write, i_commit: publish shadow, i_rd: readback request
// o_indicator: committed outputs, o_rd_data/o_rd_valid: readback, o_pending: uncommitted changes
interface output_port_bank_if #(
  parameter int DATA_W = 4,
  parameter int PORTS  = 4
);
  localparam int ID_W = $clog2(PORTS);
  logic                    i_rw;
  logic [1:0]              i_op;
  logic [DATA_W-1:0]       i_data;
  logic [ID_W-1:0]         i_port_id;
  logic                    i_commit;
  logic                    i_rd;
  logic [PORTS*DATA_W-1:0] o_indicator;
  logic [DATA_W-1:0]       o_rd_data;
  logic                    o_rd_valid;
  logic                    o_pending;
  modport master (
    output i_rw, i_op, i_data, i_port_id, i_commit, i_rd,
    input  o_indicator, o_rd_data, o_rd_valid, o_pending
  );
  modport slave (
    input  i_rw, i_op, i_data, i_port_id, i_commit, i_rd,
    output o_indicator, o_rd_data, o_rd_valid, o_pending
  );
endinterface

// File: rtl/output_port_bank.sv
// output_port_bank: port-addressed shadow register bank with commit to a visible indicator bus
// clk/reset: clock and synchronous active-high reset; bus: output_port_bank_if slave side
module output_port_bank #(
  parameter int DATA_W      = 4,
  parameter int PORTS       = 4,
  parameter int AUTO_COMMIT = 0
) (
  input logic                clk,
  input logic                reset,
  output_port_bank_if.slave  bus
);
  localparam int ID_W = $clog2(PORTS);
  logic [DATA_W-1:0]       r_shadow [PORTS];
  logic [PORTS*DATA_W-1:0] r_indicator;
  logic [DATA_W-1:0]       r_rd_data;
  logic                    r_rd_valid;
  logic                    r_pending;
  logic [PORTS*DATA_W-1:0] w_next_shadow;
  logic [PORTS*DATA_W-1:0] w_next_ind;
  logic [DATA_W-1:0]       w_old;
  logic [DATA_W-1:0]       w_new;
  logic                    w_in_range;
  logic                    w_wr;
  // PORTS need not be a power of two, so the top ID codes may name no slot
  assign w_in_range = {1'b0, bus.i_port_id} < (ID_W+1)'(PORTS);
  assign w_wr       = bus.i_rw && w_in_range;
  // pre-write slot value; feeds both the write operation and the readback
  assign w_old      = w_in_range ? r_shadow[bus.i_port_id] : '0;
  assign w_new      = bus.i_op == 2'd0 ? bus.i_data :
                      bus.i_op == 2'd1 ? w_old | bus.i_data :
                      bus.i_op == 2'd2 ? w_old & ~bus.i_data :
                                         w_old ^ bus.i_data;
  always_comb begin
    w_next_shadow = '0;
    for (int i = 0; i < PORTS; i++)
      w_next_shadow[i*DATA_W +: DATA_W] = (w_wr && bus.i_port_id == ID_W'(i)) ? w_new : r_shadow[i];
  end
  // commit publishes next-shadow so a same-cycle write is visible immediately
  assign w_next_ind = (AUTO_COMMIT != 0 || bus.i_commit) ? w_next_shadow : r_indicator;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PORTS; i++) r_shadow[i] <= '0;
      r_indicator <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      for (int i = 0; i < PORTS; i++) r_shadow[i] <= w_next_shadow[i*DATA_W +: DATA_W];
      r_indicator <= w_next_ind;
      r_pending   <= w_next_shadow != w_next_ind;
      if (bus.i_rd) r_rd_data <= w_old;
      r_rd_valid  <= bus.i_rd;
    end
  end
  assign bus.o_indicator = r_indicator;
  assign bus.o_rd_data   = r_rd_data;
  assign bus.o_rd_valid  = r_rd_valid;
  assign bus.o_pending   = r_pending;
endmodule

// File: tb/tb_output_port_bank.sv
// tb_output_port_bank: scoreboard bench for default, PORTS=3/DATA_W=8 and AUTO_COMMIT=1 banks
module tb_output_port_bank;
  typedef struct {
    int          cyc;
    string       name;
    logic [23:0] ind;
    logic        pend;
    logic        rv;
    logic [7:0]  rdd;
  } exp_t;
  logic clk;
  logic rst_a, rst_b, rst_c;
  int   cnt = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t e;
  output_port_bank_if #(.DATA_W(4), .PORTS(4)) ifa ();
  output_port_bank_if #(.DATA_W(8), .PORTS(3)) ifb ();
  output_port_bank_if #(.DATA_W(4), .PORTS(4)) ifc ();
  output_port_bank #(.DATA_W(4), .PORTS(4), .AUTO_COMMIT(0)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  output_port_bank #(.DATA_W(8), .PORTS(3), .AUTO_COMMIT(0)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));
  output_port_bank #(.DATA_W(4), .PORTS(4), .AUTO_COMMIT(1)) dut_c (.clk(clk), .reset(rst_c), .bus(ifc));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  task automatic check(string n, logic [23:0] act, logic [23:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask
  task automatic cmp(exp_t x, logic [23:0] ind, logic p, logic rv, logic [7:0] rd);
    check({x.name, ".indicator"}, ind, x.ind);
    check({x.name, ".pending"}, {23'd0, p}, {23'd0, x.pend});
    check({x.name, ".rd_valid"}, {23'd0, rv}, {23'd0, x.rv});
    check({x.name, ".rd_data"}, {16'd0, rd}, {16'd0, x.rdd});
  endtask
  always @(negedge clk) begin
    if (qa.size() != 0 && qa[0].cyc == cnt) begin
      e = qa.pop_front();
      cmp(e, {8'd0, ifa.o_indicator}, ifa.o_pending, ifa.o_rd_valid, {4'd0, ifa.o_rd_data});
    end
    if (qb.size() != 0 && qb[0].cyc == cnt) begin
      e = qb.pop_front();
      cmp(e, ifb.o_indicator, ifb.o_pending, ifb.o_rd_valid, ifb.o_rd_data);
    end
    if (qc.size() != 0 && qc[0].cyc == cnt) begin
      e = qc.pop_front();
      cmp(e, {8'd0, ifc.o_indicator}, ifc.o_pending, ifc.o_rd_valid, {4'd0, ifc.o_rd_data});
    end
  end
  task automatic step(int d, bit r, bit rw, logic [1:0] op, logic [7:0] dat, logic [1:0] id, bit cm, bit rd);
    @(negedge clk);
    if (d == 0) begin
      rst_a = r; ifa.i_rw = rw; ifa.i_op = op; ifa.i_data = dat[3:0];
      ifa.i_port_id = id; ifa.i_commit = cm; ifa.i_rd = rd;
    end else if (d == 1) begin
      rst_b = r; ifb.i_rw = rw; ifb.i_op = op; ifb.i_data = dat;
      ifb.i_port_id = id; ifb.i_commit = cm; ifb.i_rd = rd;
    end else begin
      rst_c = r; ifc.i_rw = rw; ifc.i_op = op; ifc.i_data = dat[3:0];
      ifc.i_port_id = id; ifc.i_commit = cm; ifc.i_rd = rd;
    end
  endtask
  task automatic ex(int d, string n, logic [23:0] ind, bit pd, bit rv, logic [7:0] rdd);
    exp_t x;
    x.cyc = cnt + 1; x.name = n; x.ind = ind; x.pend = pd; x.rv = rv; x.rdd = rdd;
    if (d == 0) qa.push_back(x);
    else if (d == 1) qb.push_back(x);
    else qc.push_back(x);
  endtask
  task automatic seq_a();
    step(0, 1, 0, 0, 0, 0, 0, 0);       ex(0, "a_reset", 'h0000, 0, 0, 0);
    step(0, 0, 1, 0, 'hA, 2, 0, 0);     ex(0, "a_load_nocommit", 'h0000, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);       ex(0, "a_commit", 'h0A00, 0, 0, 0);
    step(0, 0, 1, 0, 'h5, 1, 1, 0);     ex(0, "a_load", 'h0A50, 0, 0, 0);
    step(0, 0, 1, 1, 'h2, 1, 1, 0);     ex(0, "a_set", 'h0A70, 0, 0, 0);
    step(0, 0, 1, 2, 'h4, 1, 1, 0);     ex(0, "a_clear", 'h0A30, 0, 0, 0);
    step(0, 0, 1, 3, 'hF, 1, 1, 0);     ex(0, "a_toggle", 'h0AC0, 0, 0, 0);
    step(0, 0, 1, 1, 'h4, 1, 0, 0);     ex(0, "a_set_nochange", 'h0AC0, 0, 0, 0);
    step(0, 0, 1, 1, 'h1, 1, 0, 0);     ex(0, "a_set_change", 'h0AC0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1);       ex(0, "a_rd_slot1", 'h0AC0, 1, 1, 'hD);
    step(0, 0, 0, 0, 0, 0, 1, 0);       ex(0, "a_commit2", 'h0AD0, 0, 0, 'hD);
    step(0, 0, 1, 0, 'h3, 0, 1, 0);     ex(0, "a_load0", 'h0AD3, 0, 0, 'hD);
    step(0, 0, 1, 0, 'h9, 0, 1, 1);     ex(0, "a_simul", 'h0AD9, 0, 1, 'h3);
    step(0, 0, 1, 0, 'hF, 0, 0, 0);     ex(0, "a_fill0", 'h0AD9, 1, 0, 'h3);
    step(0, 0, 1, 0, 'hF, 1, 0, 0);     ex(0, "a_fill1", 'h0AD9, 1, 0, 'h3);
    step(0, 0, 1, 0, 'hF, 2, 0, 0);     ex(0, "a_fill2", 'h0AD9, 1, 0, 'h3);
    step(0, 0, 1, 0, 'hF, 3, 1, 0);     ex(0, "a_fill3", 'hFFFF, 0, 0, 'h3);
    step(0, 0, 0, 0, 0, 2, 0, 1);       ex(0, "a_rd_full", 'hFFFF, 0, 1, 'hF);
    step(0, 1, 1, 0, 'h5, 0, 1, 1);     ex(0, "a_reset_mid", 'h0000, 0, 0, 'h0);
    for (int s = 0; s < 4; s++) begin
      step(0, 0, 0, 0, 0, 2'(s), 0, 1); ex(0, "a_rd_after_reset", 'h0000, 0, 1, 'h0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);       ex(0, "a_idle", 'h0000, 0, 0, 'h0);
  endtask
  task automatic seq_b();
    step(1, 1, 0, 0, 0, 0, 0, 0);       ex(1, "b_reset", 'h000000, 0, 0, 'h00);
    step(1, 0, 1, 0, 'hFF, 3, 0, 0);    ex(1, "b_oor_write", 'h000000, 0, 0, 'h00);
    step(1, 0, 1, 0, 'hFF, 3, 1, 0);    ex(1, "b_oor_write_commit", 'h000000, 0, 0, 'h00);
    step(1, 0, 1, 0, 'h5A, 2, 1, 0);    ex(1, "b_load2", 'h5A0000, 0, 0, 'h00);
    step(1, 0, 0, 0, 0, 3, 0, 1);       ex(1, "b_oor_rd", 'h5A0000, 0, 1, 'h00);
    step(1, 0, 0, 0, 0, 2, 0, 1);       ex(1, "b_rd2", 'h5A0000, 0, 1, 'h5A);
    step(1, 0, 1, 3, 'hFF, 3, 0, 1);    ex(1, "b_oor_toggle_rd", 'h5A0000, 0, 1, 'h00);
    step(1, 0, 0, 0, 0, 0, 0, 0);       ex(1, "b_idle", 'h5A0000, 0, 0, 'h00);
  endtask
  task automatic seq_c();
    step(2, 1, 0, 0, 0, 0, 0, 0);       ex(2, "c_reset", 'h0000, 0, 0, 'h0);
    step(2, 0, 1, 0, 'h7, 3, 0, 0);     ex(2, "c_auto_load", 'h7000, 0, 0, 'h0);
    step(2, 0, 0, 0, 0, 0, 1, 0);       ex(2, "c_commit_noeffect", 'h7000, 0, 0, 'h0);
    step(2, 0, 1, 1, 'h5, 0, 0, 0);     ex(2, "c_auto_set", 'h7005, 0, 0, 'h0);
    step(2, 0, 1, 2, 'h7, 3, 0, 1);     ex(2, "c_auto_clear_rd", 'h0005, 0, 1, 'h7);
    step(2, 0, 0, 0, 0, 0, 0, 0);       ex(2, "c_idle", 'h0005, 0, 0, 'h7);
  endtask
  initial begin
    rst_a = 1; rst_b = 1; rst_c = 1;
    ifa.i_rw = 0; ifa.i_op = 0; ifa.i_data = 0; ifa.i_port_id = 0; ifa.i_commit = 0; ifa.i_rd = 0;
    ifb.i_rw = 0; ifb.i_op = 0; ifb.i_data = 0; ifb.i_port_id = 0; ifb.i_commit = 0; ifb.i_rd = 0;
    ifc.i_rw = 0; ifc.i_op = 0; ifc.i_data = 0; ifc.i_port_id = 0; ifc.i_commit = 0; ifc.i_rd = 0;
    fork
      seq_a();
      seq_b();
      seq_c();
    join
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", qa.size() + qb.size() + qc.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
